// File: rtl/fll_cfg_pkg.sv
// fll_cfg_pkg
// Shared types and constants for the FLL configuration-port initiator.
//   fll_cfg_state_e : controller FSM states
//   FLL_ADDR_DIV    : FLL divider register address (a write here waits for lock)
//   fll_cnt_width   : width of a counter that must reach both timeouts
package fll_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LOCK = 2'd2,
    ST_RESP = 2'd3
  } fll_cfg_state_e;

  localparam logic [1:0] FLL_ADDR_DIV = 2'b00;

  // Smallest width holding max(a, b) without wrapping.
  function automatic int fll_cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/fll_cfg_sync.sv
// fll_cfg_sync
// Multi-flop synchroniser for a single asynchronous level.
//   clk  : destination clock
//   srst : synchronous active-high reset, clears every stage to 0
//   d    : asynchronous input level
//   q    : synchronised level, STAGES cycles behind d
module fll_cfg_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], d};
    end
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/fll_cfg_ctrl.sv
// fll_cfg_ctrl
// Turns single-beat register commands into the FLL req/ack handshake.
// A write to the divider register additionally waits for the FLL to lock.
// Missing ack or missing lock is reported as an error response.
// Ports:
//   clk_i, rst_i                : clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o     : command handshake
//   cmd_we_i/addr_i/wdata_i     : command fields
//   rsp_valid_o/rdata_o/err_o   : one-cycle response pulse with data and error
//   busy_o                      : controller not idle
//   fll_req_o/wr_no/addr_o/wdata_o : request side towards the FLL
//   fll_ack_i/rdata_i/lock_i    : FLL side (ack and lock are asynchronous)
//   lock_o                      : synchronised lock, free-running
module fll_cfg_ctrl
  import fll_cfg_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int ACK_TIMEOUT  = 255,
  parameter int LOCK_SETTLE  = 16,
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [1:0]  cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        fll_req_o,
  output logic        fll_wr_no,
  output logic [1:0]  fll_addr_o,
  output logic [31:0] fll_wdata_o,
  input  logic        fll_ack_i,
  input  logic [31:0] fll_rdata_i,
  input  logic        fll_lock_i,
  output logic        lock_o
);

  localparam int CNT_W = fll_cnt_width(ACK_TIMEOUT, LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] BLANK_CNT   = CNT_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] ACK_TO_CNT  = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] SETTLE_CNT  = CNT_W'(LOCK_SETTLE);
  localparam logic [CNT_W-1:0] LOCK_TO_CNT = CNT_W'(LOCK_TIMEOUT);

  fll_cfg_state_e   state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_sat;
  logic             ack_sync;
  logic             lock_sync;
  logic             ack_ok;
  logic             lock_ok;

  fll_cfg_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk  (clk_i),
    .srst (rst_i),
    .d    (fll_ack_i),
    .q    (ack_sync)
  );

  fll_cfg_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk  (clk_i),
    .srst (rst_i),
    .d    (fll_lock_i),
    .q    (lock_sync)
  );

  assign lock_o = lock_sync;

  // Saturating increment so a long wait can never wrap back below a threshold.
  assign cnt_sat = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  // The first SYNC_STAGES REQ cycles may still see the ack level of the
  // previous transfer travelling through the synchroniser, so ignore them.
  assign ack_ok  = ack_sync && (cnt >= BLANK_CNT);
  assign lock_ok = lock_sync && (cnt >= SETTLE_CNT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      fll_req_o   <= 1'b0;
      fll_wr_no   <= 1'b1;
      fll_addr_o  <= '0;
      fll_wdata_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            fll_addr_o  <= cmd_addr_i;
            fll_wdata_o <= cmd_wdata_i;
            fll_wr_no   <= ~cmd_we_i;
            fll_req_o   <= 1'b1;
            cnt         <= '0;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state       <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (ack_ok) begin
            if (fll_wr_no) begin
              rsp_rdata_o <= fll_rdata_i;
            end
            fll_req_o <= 1'b0;
            cnt       <= '0;
            if (!fll_wr_no && (fll_addr_o == FLL_ADDR_DIV)) begin
              state <= ST_LOCK;
            end else begin
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b0;
              state       <= ST_RESP;
            end
          end else if (cnt == ACK_TO_CNT) begin
            fll_req_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt_sat;
          end
        end

        ST_LOCK: begin
          if (lock_ok) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            state       <= ST_RESP;
          end else if (cnt == LOCK_TO_CNT) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt_sat;
          end
        end

        ST_RESP: begin
          rsp_valid_o <= 1'b0;
          rsp_err_o   <= 1'b0;
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          state       <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fll_cfg_ctrl.sv
// tb_fll_cfg_ctrl
// Directed bench for fll_cfg_ctrl with a response scoreboard: each issued
// command pushes its expected response (data, error, arrival cycle) and a
// monitor pops and compares whenever rsp_valid_o is seen.
module tb_fll_cfg_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [1:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        fll_req;
  logic        fll_wr_n;
  logic [1:0]  fll_addr;
  logic [31:0] fll_wdata;
  logic        fll_ack;
  logic [31:0] fll_rdata;
  logic        fll_lock;
  logic        lock;

  fll_cfg_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy),
    .fll_req_o   (fll_req),
    .fll_wr_no   (fll_wr_n),
    .fll_addr_o  (fll_addr),
    .fll_wdata_o (fll_wdata),
    .fll_ack_i   (fll_ack),
    .fll_rdata_i (fll_rdata),
    .fll_lock_i  (fll_lock),
    .lock_o      (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] held     = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard side: every response must have been predicted.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("rsp cycle=%0d rdata=%h err=%0d", cyc, rsp_rdata, rsp_err);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        check("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // Waits for ready, drives one command for one accepting edge, and predicts
  // its response. t0 is the cycle in which valid was presented (cycle N).
  task automatic issue(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic err, input int lat,
                       input bit expect_rsp, output int t0);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) check("ready_timeout", 32'd0, 32'd1);
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    fll_rdata = rdata;
    cmd_valid = 1'b1;
    t0 = cyc;
    $display("cmd cycle=%0d we=%0d addr=%0d wdata=%h", t0, we, addr, wdata);
    if (expect_rsp) begin
      if (!we && !err) held = rdata;
      exp_q.push_back('{held, err, t0 + lat});
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("rsp_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    int t0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    fll_ack   = 1'b0;
    fll_rdata = '0;
    fll_lock  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_wr_n", {31'd0, fll_wr_n}, 32'd1);
    check("rst_req", {31'd0, fll_req}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_lock", {31'd0, lock}, 32'd0);
    check("rst_addr", {30'd0, fll_addr}, 32'd0);
    check("rst_wdata", fll_wdata, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);

    fll_ack  = 1'b1;
    fll_lock = 1'b1;
    repeat (4) @(negedge clk);

    // Read with ack tied high: req N+1..N+3, response N+4, ready N+5
    issue(1'b0, 2'd0, 32'd0, 32'h0000_0003, 1'b0, 4, 1'b1, t0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("rd_req_%0d", k), {31'd0, fll_req}, (k <= 3) ? 32'd1 : 32'd0);
      if (k == 5) check("rd_ready", {31'd0, cmd_ready}, 32'd1);
    end
    wait_rsp(50);

    // Write to divider with lock high: 3 REQ + 17 LOCK cycles, response N+21
    issue(1'b1, 2'd0, 32'd2, 32'hFFFF_FFFF, 1'b0, 21, 1'b1, t0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("wr_req_%0d", k), {31'd0, fll_req}, (k <= 3) ? 32'd1 : 32'd0);
      check("wr_wr_n", {31'd0, fll_wr_n}, 32'd0);
      check("wr_wdata", fll_wdata, 32'd2);
    end
    check("wr_busy_lock", {31'd0, busy}, 32'd1);
    wait_rsp(50);

    // Ack timeout: req high for 256 cycles, error response at N+257
    fll_ack = 1'b0;
    repeat (4) @(negedge clk);
    issue(1'b0, 2'd3, 32'd0, 32'h0000_1234, 1'b1, 257, 1'b1, t0);
    for (int k = 1; k <= 257; k++) begin
      @(negedge clk);
      if (k == 256) check("ato_req_last", {31'd0, fll_req}, 32'd1);
      if (k == 257) check("ato_req_drop", {31'd0, fll_req}, 32'd0);
    end
    wait_rsp(20);

    // Lock timeout: ack at end of N+3, 1024 LOCK cycles, error response N+1028
    fll_ack  = 1'b1;
    fll_lock = 1'b0;
    repeat (4) @(negedge clk);
    issue(1'b1, 2'd0, 32'd5, 32'd0, 1'b1, 1028, 1'b1, t0);
    wait_rsp(1100);
    check("lto_lock_o", {31'd0, lock}, 32'd0);

    // Lock rises in LOCK cycle 40 (cycle N+44): response at N+47
    issue(1'b1, 2'd0, 32'd7, 32'd0, 1'b0, 47, 1'b1, t0);
    repeat (43) @(posedge clk);
    #1;
    fll_lock = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("lock_lag_%0d", k), {31'd0, lock}, (k == 2) ? 32'd1 : 32'd0);
    end
    wait_rsp(50);

    // Write to addr 1 with lock low must not wait for lock
    fll_lock = 1'b0;
    repeat (4) @(negedge clk);
    issue(1'b1, 2'd1, 32'hCAFE_0001, 32'd0, 1'b0, 4, 1'b1, t0);
    wait_rsp(50);

    // Reset during REQ: no response, idle outputs next cycle
    fll_ack = 1'b0;
    repeat (4) @(negedge clk);
    issue(1'b0, 2'd1, 32'd0, 32'h5555_5555, 1'b0, 0, 1'b0, t0);
    repeat (10) @(negedge clk);
    check("mid_req_before", {31'd0, fll_req}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    held = '0;
    @(negedge clk);
    check("mid_req", {31'd0, fll_req}, 32'd0);
    check("mid_ready", {31'd0, cmd_ready}, 32'd1);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_rdata", rsp_rdata, 32'd0);
    fll_ack  = 1'b1;
    fll_lock = 1'b1;
    repeat (6) @(negedge clk);

    // Back-to-back commands after reset
    issue(1'b0, 2'd2, 32'd0, 32'hA5A5_0001, 1'b0, 4, 1'b1, t0);
    issue(1'b1, 2'd3, 32'h0000_00FF, 32'd0, 1'b0, 4, 1'b1, t0);
    issue(1'b0, 2'd1, 32'd0, 32'hDEAD_BEEF, 1'b0, 4, 1'b1, t0);
    issue(1'b1, 2'd0, 32'd9, 32'd0, 1'b0, 21, 1'b1, t0);
    wait_rsp(100);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
